// File: rtl/pwm_bank_pkg.sv
// +--------------------------------------------------------------------+
// | pwm_bank_pkg : register map, CTRL bit positions, default sizes     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pwm_bank_pkg;

  localparam int DEF_NUM_CH  = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 12;

  localparam logic [3:0] ADDR_OUT_EN   = 4'h0;
  localparam logic [3:0] ADDR_PWM_EN   = 4'h1;
  localparam logic [3:0] ADDR_CTRL     = 4'h2;
  localparam logic [3:0] ADDR_PRESC_LO = 4'h3;
  localparam logic [3:0] ADDR_PRESC_HI = 4'h4;
  localparam logic [3:0] ADDR_DUTY0    = 4'h8;

  localparam int CTRL_CENTER_BIT = 0;
  localparam int CTRL_RUN_BIT    = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

`default_nettype wire

// File: rtl/pwm_timebase.sv
// +--------------------------------------------------------------------+
// | pwm_timebase : prescaler, edge/center period counter, boundary     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               center,
  input  logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   cnt,
  output logic               boundary
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [PRESC_W-1:0] r_psc;
  logic [CNT_W-1:0]   r_cnt;
  dir_e               r_dir;
  logic               r_center_q;

  logic               w_tick;
  dir_e               w_dir_eff;
  dir_e               w_dir_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  always_comb begin
    // >= rather than == so a PRESC shrunk below the running count still ticks
    w_tick    = run && (r_psc >= presc);
    // a CENTER toggle restarts the direction as up in the very cycle it lands
    w_dir_eff = (center != r_center_q) ? DIR_UP : r_dir;
    w_dir_nxt = w_dir_eff;
    w_cnt_nxt = r_cnt;
    if (!center) begin
      w_cnt_nxt = r_cnt + 1'b1;
      w_dir_nxt = DIR_UP;
    end else if (w_dir_eff == DIR_UP && r_cnt != MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else begin
      w_cnt_nxt = r_cnt - 1'b1;
      w_dir_nxt = DIR_DOWN;
    end
    if (w_cnt_nxt == '0) begin
      w_dir_nxt = DIR_UP;
    end
    boundary = w_tick && (w_cnt_nxt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc      <= '0;
      r_cnt      <= '0;
      r_dir      <= DIR_UP;
      r_center_q <= 1'b0;
    end else begin
      r_center_q <= center;
      if (!run) begin
        r_psc <= '0;
        r_cnt <= '0;
        r_dir <= DIR_UP;
      end else if (w_tick) begin
        r_psc <= '0;
        r_cnt <= w_cnt_nxt;
        r_dir <= w_dir_nxt;
      end else begin
        r_psc <= r_psc + 1'b1;
        r_dir <= w_dir_eff;
      end
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pwm_bank.sv
// +--------------------------------------------------------------------+
// | pwm_bank : register file, duty shadowing and per-channel compare   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              sync
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [NUM_CH-1:0]            r_out_en;
  logic [NUM_CH-1:0]            r_pwm_en;
  logic                         r_center;
  logic                         r_run;
  logic [PRESC_W-1:0]           r_presc;
  logic [NUM_CH-1:0][CNT_W-1:0] r_duty_pend;
  logic [NUM_CH-1:0][CNT_W-1:0] r_duty_act;
  logic [NUM_CH-1:0]            r_out;

  logic [CNT_W-1:0]             w_cnt;
  logic                         w_boundary;
  logic [NUM_CH-1:0]            w_pwm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_en    <= '0;
      r_pwm_en    <= '0;
      r_center    <= 1'b0;
      r_run       <= 1'b0;
      r_presc     <= '0;
      r_duty_pend <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_OUT_EN: r_out_en <= wr_data[NUM_CH-1:0];
        ADDR_PWM_EN: r_pwm_en <= wr_data[NUM_CH-1:0];
        ADDR_CTRL: begin
          r_center <= wr_data[CTRL_CENTER_BIT];
          r_run    <= wr_data[CTRL_RUN_BIT];
        end
        default: ;
      endcase
      // PRESC is split over two byte addresses; bits beyond PRESC_W are dropped
      for (int b = 0; b < PRESC_W; b++) begin
        if ((b < 8 && wr_addr == ADDR_PRESC_LO) || (b >= 8 && wr_addr == ADDR_PRESC_HI)) begin
          r_presc[b] <= wr_data[b % 8];
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == ADDR_DUTY0 + 4'(i)) begin
          r_duty_pend[i] <= wr_data[CNT_W-1:0];
        end
      end
    end
  end

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .run      (r_run),
    .center   (r_center),
    .presc    (r_presc),
    .cnt      (w_cnt),
    .boundary (w_boundary)
  );

  // while stopped the active duty tracks pending so a restart uses fresh values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_act <= '0;
    end else if (!r_run || w_boundary) begin
      r_duty_act <= r_duty_pend;
    end
  end

  always_comb begin
    w_pwm = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pwm[i] = r_run && ((r_duty_act[i] == MAX) || (w_cnt < r_duty_act[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= r_out_en & ((r_pwm_en & w_pwm) | ~r_pwm_en);
    end
  end

  assign out  = r_out;
  assign sync = w_boundary;

endmodule

`default_nettype wire
